sram_input_ctrl: RTL and testbench

//  Initiator for the single-port input SRAM (1-cycle registered read, cen_n active-low, wen active-high).
//  - Accepts LOAD or DUMP commands over a valid/ready command port.
//  - LOAD streams words from a valid/ready input into consecutive SRAM addresses.
//  - DUMP reads consecutive addresses and streams the words out on a valid/ready output,

---
 rtl/sram_input_ctrl_if.sv | 31 +++
 rtl/sram_input_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sram_input_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_input_ctrl_if.sv
// Command, LOAD-data and DUMP-data handshakes of the input SRAM controller.
// master = data mover side, slave = sram_input_ctrl.
interface sram_input_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [ADDR_WIDTH:0]   cmd_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  done;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_len,
        output in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_len,
        input  in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, done
    );
endinterface

// File: rtl/sram_input_ctrl.sv
// Initiator for the single-port input SRAM: LOAD streams words in, DUMP
// streams words out through a 2-entry FIFO that absorbs read latency.
// Ports: clk, rst_n (async, active-low); bus (slave: cmd/in/out/done);
//        o_sram_cen_n, o_sram_wen, o_sram_addr, o_sram_wdata, i_sram_rdata.
module sram_input_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_input_ctrl_if.slave      bus,
    output logic                  o_sram_cen_n,
    output logic                  o_sram_wen,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_wdata,
    input  logic [DATA_WIDTH-1:0] i_sram_rdata
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DUMP,
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CW-1:0]         r_len;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_pops;
    logic                  r_inflight;
    logic [1:0]            r_fifo_cnt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_wdata_q;

    logic                  w_accept;
    logic [CW-1:0]         w_len_clamped;
    logic                  w_in_ready;
    logic                  w_wr;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_rd;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic                  w_last_wr;
    logic                  w_last_pop;

    assign w_accept      = bus.cmd_valid && (r_state == S_IDLE);
    assign w_len_clamped = (bus.cmd_len > CW'(DEPTH)) ? CW'(DEPTH)
                                                      : bus.cmd_len;
    assign w_in_ready    = (r_state == S_LOAD) && (r_cnt < r_len);
    assign w_wr          = w_in_ready && bus.in_valid;
    assign w_pop         = (r_fifo_cnt != 2'd0) && bus.out_ready;
    // Words held after this cycle if no new read is issued.
    assign w_occ         = {1'b0, r_fifo_cnt} + {2'b00, r_inflight}
                         - {2'b00, w_pop};
    assign w_rd          = (r_state == S_DUMP) && (r_cnt < r_len)
                         && (w_occ < 3'd2);
    // Wraps mod DEPTH by truncation to ADDR_WIDTH bits.
    assign w_beat_addr   = r_base + r_cnt[ADDR_WIDTH-1:0];
    assign w_last_wr     = w_wr && (r_cnt == r_len - CW'(1));
    assign w_last_pop    = (r_state == S_DUMP) && w_pop
                         && (r_pops == r_len - CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_len_clamped == '0) begin
                        w_next = S_FIN;
                    end else if (bus.cmd_op) begin
                        w_next = S_DUMP;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD: if (w_last_wr) w_next = S_FIN;
            S_DUMP: if (w_last_pop) w_next = S_FIN;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (r_state == S_IDLE);
        bus.in_ready  = w_in_ready;
        bus.out_valid = (r_fifo_cnt != 2'd0);
        bus.out_data  = r_head;
        bus.done      = (r_state == S_FIN);
        o_sram_cen_n  = !(w_wr || w_rd);
        o_sram_wen    = w_wr;
        o_sram_addr   = (w_wr || w_rd) ? w_beat_addr : r_addr_q;
        o_sram_wdata  = w_wr ? bus.in_data : r_wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_pops     <= '0;
            r_inflight <= 1'b0;
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
        end else begin
            if (w_accept) begin
                r_base <= bus.cmd_base;
                r_len  <= w_len_clamped;
                r_cnt  <= '0;
                r_pops <= '0;
            end else begin
                if (w_wr || w_rd) r_cnt <= r_cnt + CW'(1);
                if (w_pop) r_pops <= r_pops + CW'(1);
            end
            r_inflight <= w_rd;
            if (w_wr || w_rd) r_addr_q <= w_beat_addr;
            if (w_wr) r_wdata_q <= bus.in_data;
        end
    end

    // Read data returns one cycle after issue and is pushed then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_cnt <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            unique case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_fifo_cnt == 2'd0) r_head <= i_sram_rdata;
                    else r_tail <= i_sram_rdata;
                    r_fifo_cnt <= r_fifo_cnt + 2'd1;
                end
                2'b01: begin
                    r_head     <= r_tail;
                    r_fifo_cnt <= r_fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_fifo_cnt == 2'd1) begin
                        r_head <= i_sram_rdata;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_sram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_input_ctrl.sv
// Scoreboard bench for sram_input_ctrl with a behavioural SRAM and
// a reference memory image driving expected writes, reads and outputs.
module tb_sram_input_ctrl;
    logic        clk;
    logic        rst_n;
    logic        sram_cen_n;
    logic        sram_wen;
    logic [6:0]  sram_addr;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata;

    sram_input_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(7)) bus ();

    sram_input_ctrl #(
        .DATA_WIDTH(64), .ADDR_WIDTH(7), .DEPTH(128)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .o_sram_cen_n (sram_cen_n),
        .o_sram_wen   (sram_wen),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [128];
    always @(posedge clk) begin
        if (!sram_cen_n) begin
            if (sram_wen) mem[sram_addr] <= sram_wdata;
            else sram_rdata <= mem[sram_addr];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(bit ok, string name,
                                logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    logic [63:0] ref_mem [128];
    logic [6:0]  exp_wa [$];
    logic [63:0] exp_wd [$];
    logic [6:0]  exp_rd [$];
    logic [63:0] exp_out [$];
    int beats_exp = 0;
    int beats_seen = 0;
    int rd_total = 0;
    int pop_total = 0;
    bit done_due = 0;
    bit zero_pend = 0;
    bit prev_stall = 0;
    logic [63:0] prev_data;
    bit rdy_rand = 0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_wa.delete();
            exp_wd.delete();
            exp_rd.delete();
            exp_out.delete();
            beats_seen = beats_exp;
            rd_total = 0;
            pop_total = 0;
            done_due = 0;
            prev_stall = 0;
        end else begin
            if (bus.done || done_due || zero_pend)
                chk(bus.done == (done_due || zero_pend), "done_pulse",
                    64'(bus.done), 64'(done_due || zero_pend));
            done_due = 0;
            if (prev_stall)
                chk(bus.out_valid && bus.out_data === prev_data,
                    "stall_hold", bus.out_data, prev_data);
            if (!sram_cen_n && sram_wen) begin
                if (exp_wa.size() == 0) begin
                    chk(0, "unexp_write", 64'(sram_addr), 0);
                end else begin
                    chk(sram_addr == exp_wa[0], "wr_addr",
                        64'(sram_addr), 64'(exp_wa[0]));
                    chk(sram_wdata === exp_wd[0], "wr_data",
                        sram_wdata, exp_wd[0]);
                    void'(exp_wa.pop_front());
                    void'(exp_wd.pop_front());
                    beats_seen++;
                    if (beats_seen == beats_exp) done_due = 1;
                end
            end
            if (!sram_cen_n && !sram_wen) begin
                rd_total++;
                if (exp_rd.size() == 0) begin
                    chk(0, "unexp_read", 64'(sram_addr), 0);
                end else begin
                    chk(sram_addr == exp_rd[0], "rd_addr",
                        64'(sram_addr), 64'(exp_rd[0]));
                    void'(exp_rd.pop_front());
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                pop_total++;
                if (exp_out.size() == 0) begin
                    chk(0, "unexp_out", bus.out_data, 0);
                end else begin
                    chk(bus.out_data === exp_out[0], "out_data",
                        bus.out_data, exp_out[0]);
                    void'(exp_out.pop_front());
                    beats_seen++;
                    if (beats_seen == beats_exp) done_due = 1;
                end
            end
            if (!sram_cen_n && !sram_wen)
                chk(rd_total - pop_total <= 2, "held_words",
                    64'(rd_total - pop_total), 2);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic send_cmd(input bit op, input logic [6:0] base,
                            input logic [7:0] len, output bit ok);
        bus.cmd_op = op;
        bus.cmd_base = base;
        bus.cmd_len = len;
        bus.cmd_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk(0, "cmd_accept_timeout", 0, 1);
    endtask

    task automatic zero_len_check();
        zero_pend = 1;
        @(negedge clk);
        chk(sram_cen_n == 1'b1, "zero_cen_n", 64'(sram_cen_n), 1);
        chk(!bus.in_ready && !bus.out_valid, "zero_no_hs",
            64'({bus.in_ready, bus.out_valid}), 0);
        @(posedge clk);
        #1;
        zero_pend = 0;
    endtask

    task automatic do_load(input logic [6:0] base, input logic [7:0] len,
                           input bit seq, input bit gaps);
        int eff;
        bit ok;
        bit hs;
        int k;
        logic [63:0] dq [$];
        eff = (len > 128) ? 128 : int'(len);
        for (int i = 0; i < eff; i++)
            dq.push_back(seq ? 64'hA0 + 64'(i) : {$urandom, $urandom});
        send_cmd(1'b0, base, len, ok);
        if (!ok) return;
        for (int i = 0; i < eff; i++) begin
            exp_wa.push_back(7'((int'(base) + i) % 128));
            exp_wd.push_back(dq[i]);
            ref_mem[(int'(base) + i) % 128] = dq[i];
        end
        beats_exp += eff;
        if (eff == 0) begin
            zero_len_check();
            return;
        end
        k = 0;
        for (int t = 0; t < 2000 && k < eff; t++) begin
            bus.in_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
            bus.in_data = bus.in_valid ? dq[k] : {$urandom, $urandom};
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
        end
        bus.in_valid = 1'b0;
        if (k != eff) chk(0, "load_timeout", 64'(k), 64'(eff));
    endtask

    task automatic do_dump(input logic [6:0] base, input logic [7:0] len);
        int eff;
        bit ok;
        eff = (len > 128) ? 128 : int'(len);
        send_cmd(1'b1, base, len, ok);
        if (!ok) return;
        for (int i = 0; i < eff; i++) begin
            exp_rd.push_back(7'((int'(base) + i) % 128));
            exp_out.push_back(ref_mem[(int'(base) + i) % 128]);
        end
        beats_exp += eff;
        if (eff == 0) zero_len_check();
    endtask

    task automatic wait_quiet();
        int t;
        for (t = 0; t < 3000; t++) begin
            @(posedge clk);
            if (beats_seen == beats_exp) break;
        end
        if (t == 3000) chk(0, "quiet_timeout", 64'(beats_seen),
                           64'(beats_exp));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = {$urandom, $urandom};
            mem[i] = ref_mem[i];
        end
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 1'b0;
        bus.cmd_base = '0;
        bus.cmd_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(bus.cmd_ready == 1'b1, "rst_cmd_ready", 64'(bus.cmd_ready), 1);
        chk(bus.in_ready == 1'b0, "rst_in_ready", 64'(bus.in_ready), 0);
        chk(bus.out_valid == 1'b0, "rst_out_valid", 64'(bus.out_valid), 0);
        chk(bus.out_data == 64'd0, "rst_out_data", bus.out_data, 0);
        chk(bus.done == 1'b0, "rst_done", 64'(bus.done), 0);
        chk(sram_cen_n == 1'b1, "rst_cen_n", 64'(sram_cen_n), 1);
        chk(sram_wen == 1'b0, "rst_wen", 64'(sram_wen), 0);
        chk(sram_addr == 7'd0, "rst_addr", 64'(sram_addr), 0);
        chk(sram_wdata == 64'd0, "rst_wdata", sram_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_load(7'h7E, 8'd4, 1'b1, 1'b1);
        wait_quiet();

        rdy_rand = 0;
        do_dump(7'h7E, 8'd4);
        @(negedge clk);
        chk(!bus.out_valid, "lat_c1", 64'(bus.out_valid), 0);
        @(negedge clk);
        chk(!bus.out_valid, "lat_c2", 64'(bus.out_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(bus.out_valid, "lat_stream", 64'(bus.out_valid), 1);
        end
        @(negedge clk);
        chk(!bus.out_valid && bus.done, "lat_end",
            64'({bus.out_valid, bus.done}), 1);
        wait_quiet();

        do_load(7'h20, 8'd16, 1'b0, 1'b1);
        wait_quiet();
        rdy_rand = 1;
        do_dump(7'h20, 8'd16);
        wait_quiet();

        do_load(7'h10, 8'd0, 1'b0, 1'b0);
        wait_quiet();
        do_dump(7'h10, 8'd0);
        wait_quiet();

        rdy_rand = 1;
        do_dump(7'h05, 8'd200);
        wait_quiet();

        rdy_rand = 0;
        p0 = pop_total;
        do_dump(7'h30, 8'd20);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (pop_total >= p0 + 5) break;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk(bus.cmd_ready == 1'b1, "mid_rst_cmd_ready",
            64'(bus.cmd_ready), 1);
        chk(!bus.out_valid && bus.out_data == 64'd0, "mid_rst_out",
            bus.out_data, 0);
        chk(sram_cen_n && !sram_wen && sram_addr == 7'd0
            && sram_wdata == 64'd0, "mid_rst_sram", 64'(sram_addr), 0);
        chk(!bus.done && !bus.in_ready, "mid_rst_done",
            64'({bus.done, bus.in_ready}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(bus.cmd_ready && !bus.done && !bus.out_valid,
                "post_rst_idle",
                64'({bus.cmd_ready, bus.done, bus.out_valid}), 64'b100);
        end
        @(posedge clk);
        #1;

        do_dump(7'h7F, 8'd3);
        wait_quiet();
        chk(beats_seen == beats_exp, "all_beats", 64'(beats_seen),
            64'(beats_exp));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
